// File: rtl/led_anim_pkg.sv
// Shared types and width constants for the LED animation sequencer.
package led_anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } led_seq_state_e;

    localparam int GAP_W     = 6;
    localparam int TIMEOUT_W = 8;
    localparam int TMR_W     = 8;

    // Load value for a GAP of g cycles; g=0 behaves as a single cycle.
    function automatic logic [TMR_W-1:0] gap_load(input logic [GAP_W-1:0] g);
        if (g == 6'd0) begin
            gap_load = {TMR_W{1'b0}};
        end else begin
            gap_load = {{(TMR_W-GAP_W){1'b0}}, g - 6'd1};
        end
    endfunction

    // Load value giving t WAIT cycles before the watchdog fires; t=0 behaves as 1.
    function automatic logic [TMR_W-1:0] timeout_load(input logic [TIMEOUT_W-1:0] t);
        if (t == 8'd0) begin
            timeout_load = {TMR_W{1'b0}};
        end else begin
            timeout_load = t - 8'd1;
        end
    endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Loadable down-counter with zero flag, shared between GAP timing and the WAIT watchdog.
module led_seq_timer
    import led_anim_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/led_seq_controller.sv
// Steps a one-hot LED enable across NUM_CH channels, handshaking each step with a PWM controller.
// Define LED_SEQ_PINGPONG_EN to bounce the index 0..NUM_CH-1..0 instead of wrapping.
module led_seq_controller
    import led_anim_pkg::*;
#(
    parameter int                   NUM_CH  = 8,
    parameter logic [GAP_W-1:0]     GAP     = 6'd20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT = 8'd200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      step_done,
    output logic                      start,
    output logic [NUM_CH-1:0]         ch_sel,
    output logic [$clog2(NUM_CH)-1:0] ch_idx,
    output logic                      busy,
    output logic                      cycle_done,
    output logic                      err
);

    localparam int                IDX_W     = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1'b1);
    localparam logic [NUM_CH-1:0] CH_NONE   = {NUM_CH{1'b0}};
    localparam logic [TMR_W-1:0]  WDOG_LOAD = timeout_load(TIMEOUT);
    localparam logic [TMR_W-1:0]  GAP_LOAD  = gap_load(GAP);

    led_seq_state_e    state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              start_r;
    logic [NUM_CH-1:0] ch_sel_r;
    logic              busy_r;
    logic              cycle_done_r;
    logic              err_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              wrap_s;
    logic              tmr_load_s;
    logic [TMR_W-1:0]  tmr_val_s;
    logic              tmr_dec_s;
    logic              tmr_zero_s;
`ifdef LED_SEQ_PINGPONG_EN
    logic              dir_up_r;
    logic              dir_nxt_s;
`endif

    led_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .dec      (tmr_dec_s),
        .zero     (tmr_zero_s)
    );

    // Index the sequencer moves to at the end of the current GAP.
    always_comb begin
        idx_nxt_s = idx_r;
`ifdef LED_SEQ_PINGPONG_EN
        dir_nxt_s = dir_up_r;
        if (dir_up_r) begin
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = idx_r - IDX_ONE;
                dir_nxt_s = 1'b0;
            end else begin
                idx_nxt_s = idx_r + IDX_ONE;
            end
        end else begin
            if (idx_r == IDX_ZERO) begin
                idx_nxt_s = idx_r + IDX_ONE;
                dir_nxt_s = 1'b1;
            end else if (idx_r == IDX_ONE) begin
                idx_nxt_s = IDX_ZERO;
                dir_nxt_s = 1'b1;
            end else begin
                idx_nxt_s = idx_r - IDX_ONE;
            end
        end
`else
        if (idx_r == IDX_LAST) begin
            idx_nxt_s = IDX_ZERO;
        end else begin
            idx_nxt_s = idx_r + IDX_ONE;
        end
`endif
        wrap_s = (idx_nxt_s == IDX_ZERO);
    end

    // Timer arms the watchdog on START and the gap when WAIT ends.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {TMR_W{1'b0}};
        tmr_dec_s  = 1'b0;
        case (state_r)
            ST_START: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = WDOG_LOAD;
            end
            ST_WAIT: begin
                if (step_done || tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = GAP_LOAD;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_dec_s = ~tmr_zero_s;
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; every output is registered from its next-state value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            start_r      <= 1'b0;
            ch_sel_r     <= CH_NONE;
            busy_r       <= 1'b0;
            cycle_done_r <= 1'b0;
            err_r        <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
            dir_up_r     <= 1'b1;
`endif
        end else begin
            start_r      <= 1'b0;
            cycle_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r  <= ST_START;
                        start_r  <= 1'b1;
                        ch_sel_r <= CH_ONE << idx_r;
                        busy_r   <= 1'b1;
                        err_r    <= 1'b0;
                    end else begin
                        ch_sel_r <= CH_NONE;
                        busy_r   <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // step_done outranks a watchdog expiry in the same cycle
                    if (step_done) begin
                        state_r  <= ST_GAP;
                        ch_sel_r <= CH_NONE;
                    end else if (tmr_zero_s) begin
                        state_r  <= ST_GAP;
                        ch_sel_r <= CH_NONE;
                        err_r    <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero_s) begin
                        idx_r        <= idx_nxt_s;
                        cycle_done_r <= wrap_s;
`ifdef LED_SEQ_PINGPONG_EN
                        dir_up_r     <= dir_nxt_s;
`endif
                        if (run) begin
                            state_r  <= ST_START;
                            start_r  <= 1'b1;
                            ch_sel_r <= CH_ONE << idx_nxt_s;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_GAP;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ch_sel_r <= CH_NONE;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign start      = start_r;
    assign ch_sel     = ch_sel_r;
    assign ch_idx     = idx_r;
    assign busy       = busy_r;
    assign cycle_done = cycle_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_led_seq_controller.sv
// Scoreboarded bench for led_seq_controller with NUM_CH=4, GAP=3, TIMEOUT=50.
module tb_led_seq_controller;

    localparam int NCH    = 4;
    localparam int GAP_C  = 3;
    localparam int TO_C   = 50;
    localparam int RESP   = 6;
    localparam int PERIOD = 10;
`ifdef LED_SEQ_PINGPONG_EN
    localparam int SEQ [0:6] = '{0, 1, 2, 3, 2, 1, 0};
    localparam int CD_POS  = 6;
    localparam int END_IDX = 1;
`else
    localparam int SEQ [0:6] = '{0, 1, 2, 3, 0, 1, 2};
    localparam int CD_POS  = 4;
    localparam int END_IDX = 3;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           step_done;
    logic           start;
    logic [NCH-1:0] ch_sel;
    logic [1:0]     ch_idx;
    logic           busy;
    logic           cycle_done;
    logic           err;

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         cd_count = 0;
    logic [1:0] exp_idx_q [$];

    led_seq_controller #(
        .NUM_CH  (NCH),
        .GAP     (6'd3),
        .TIMEOUT (8'd50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step_done  (step_done),
        .start      (start),
        .ch_sel     (ch_sel),
        .ch_idx     (ch_idx),
        .busy       (busy),
        .cycle_done (cycle_done),
        .err        (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every start pulse must match the next expected channel index.
    initial forever begin
        logic [1:0] e;
        @(negedge clk);
        if (!rst && cycle_done) cd_count++;
        if (!rst && start) begin
            checks++;
            if (exp_idx_q.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected ch_idx=%0d required no start", ch_idx);
            end else begin
                e = exp_idx_q.pop_front();
                if (ch_idx !== e) begin
                    errors++;
                    $display("FAIL start_idx ch_idx=%0d required %0d", ch_idx, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    task automatic wait_start(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic pulse_step(input int delay);
        repeat (delay) @(negedge clk);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        step_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        run       = 1'b0;
        step_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start, ch_sel, ch_idx, busy, cycle_done, err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {start, ch_sel, ch_idx, busy, cycle_done, err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start, busy, ch_idx} !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %b required 0", {start, busy, ch_idx});
        end
    endtask

    // step_done returned five cycles after each start pulse ends.
    task automatic test_sequence();
        bit         ok;
        int         at;
        int         prev;
        logic [3:0] oh;
        prev     = 0;
        cd_count = 0;
        for (int i = 0; i < 7; i++) exp_idx_q.push_back(2'(SEQ[i]));
        run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_start(30, ok, at);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL seq_start_timeout step=%0d no start within 30 cycles", i);
            end
            if (i > 0) begin
                checks++;
                if (at - prev !== PERIOD) begin
                    errors++;
                    $display("FAIL seq_period step=%0d got %0d required %0d", i, at - prev, PERIOD);
                end
            end
            oh = 4'b0001 << SEQ[i];
            checks++;
            if (ch_sel !== oh) begin
                errors++;
                $display("FAIL seq_ch_sel step=%0d got %b required %b", i, ch_sel, oh);
            end
            checks++;
            if (cycle_done !== 1'(i == CD_POS)) begin
                errors++;
                $display("FAIL seq_cycle_done step=%0d got %b required %b", i, cycle_done, (i == CD_POS));
            end
            prev = at;
            if (i == 6) run = 1'b0;
            pulse_step(RESP);
        end
        wait_idle(40, ok);
        checks++;
        if (!ok || ch_idx !== 2'(END_IDX)) begin
            errors++;
            $display("FAIL seq_end idle=%0d ch_idx=%0d required idle=1 ch_idx=%0d", ok, ch_idx, END_IDX);
        end
        checks++;
        if (cd_count !== 1) begin
            errors++;
            $display("FAIL seq_cycle_done_count got %0d required 1", cd_count);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit found;
        int at;
        int n;
        int err_at;
        do_reset();
        exp_idx_q.push_back(2'd0);
        exp_idx_q.push_back(2'd1);
        run = 1'b1;
        wait_start(10, ok, at);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_first_start no start within 10 cycles");
        end
        found = 1'b0;
        n     = 0;
        for (int i = 1; i <= 100 && !found; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                found = 1'b1;
                n     = i;
            end
        end
        err_at = cyc;
        checks++;
        if (!found || n !== TO_C + 1) begin
            errors++;
            $display("FAIL to_err_latency found=%0d cycles=%0d required %0d", found, n, TO_C + 1);
        end
        for (int k = 0; k < GAP_C; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (ch_sel !== 4'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL to_gap_outputs k=%0d ch_sel=%b busy=%b required 0000/1", k, ch_sel, busy);
            end
        end
        wait_start(10, ok, at);
        checks++;
        if (!ok || at - err_at !== GAP_C) begin
            errors++;
            $display("FAIL to_restart ok=%0d delay=%0d required %0d", ok, at - err_at, GAP_C);
        end
        checks++;
        if (ch_sel !== 4'b0010 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky ch_sel=%b err=%b required 0010/1", ch_sel, err);
        end
        run = 1'b0;
        pulse_step(RESP);
        wait_idle(30, ok);
        checks++;
        if (!ok || ch_idx !== 2'd2) begin
            errors++;
            $display("FAIL to_end idle=%0d ch_idx=%0d required idle=1 ch_idx=2", ok, ch_idx);
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        int at;
        int sc;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rd_err_held got %b required 1", err);
        end
        exp_idx_q.push_back(2'd2);
        run = 1'b1;
        wait_start(10, ok, at);
        checks++;
        if (!ok || err !== 1'b0) begin
            errors++;
            $display("FAIL rd_err_clear ok=%0d err=%b required 1/0", ok, err);
        end
        @(negedge clk);
        run = 1'b0;
        pulse_step(4);
        wait_idle(30, ok);
        checks++;
        if (!ok || ch_idx !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_end idle=%0d ch_idx=%0d busy=%b required 1/3/0", ok, ch_idx, busy);
        end
        sc = 0;
        repeat (15) begin
            @(negedge clk);
            if (start === 1'b1) sc++;
        end
        checks++;
        if (sc !== 0) begin
            errors++;
            $display("FAIL rd_no_start got %0d starts required 0", sc);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int at0;
        int at;
        do_reset();
        exp_idx_q.push_back(2'd0);
        exp_idx_q.push_back(2'd1);
        run = 1'b1;
        wait_start(10, ok, at0);
        repeat (TO_C) @(negedge clk);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        checks++;
        if (err !== 1'b0 || ch_sel !== 4'd0) begin
            errors++;
            $display("FAIL sim_tie err=%b ch_sel=%b required 0/0000", err, ch_sel);
        end
        // a stray step_done during GAP must not disturb the timing
        @(negedge clk);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        wait_start(10, ok, at);
        checks++;
        if (!ok || at - at0 !== 1 + TO_C + GAP_C) begin
            errors++;
            $display("FAIL sim_period ok=%0d got %0d required %0d", ok, at - at0, 1 + TO_C + GAP_C);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL sim_err got %b required 0", err);
        end
        run = 1'b0;
        pulse_step(RESP);
        wait_idle(30, ok);
        checks++;
        if (!ok || ch_idx !== 2'd2) begin
            errors++;
            $display("FAIL sim_end idle=%0d ch_idx=%0d required idle=1 ch_idx=2", ok, ch_idx);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int at;
        do_reset();
        for (int k = 0; k < 3; k++) exp_idx_q.push_back(2'(k));
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start(30, ok, at);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rm_start_timeout step=%0d", k);
            end
            if (k < 2) pulse_step(RESP);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({start, ch_sel, ch_idx, busy, cycle_done, err} !== 10'd0) begin
            errors++;
            $display("FAIL rm_async_clear got %b required 0", {start, ch_sel, ch_idx, busy, cycle_done, err});
        end
        @(negedge clk);
        exp_idx_q.push_back(2'd0);
        rst = 1'b0;
        wait_start(10, ok, at);
        checks++;
        if (!ok || ch_idx !== 2'd0 || ch_sel !== 4'b0001) begin
            errors++;
            $display("FAIL rm_restart ok=%0d ch_idx=%0d ch_sel=%b required 1/0/0001", ok, ch_idx, ch_sel);
        end
        run = 1'b0;
        pulse_step(RESP);
        wait_idle(30, ok);
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        step_done = 1'b0;
        test_reset();
        test_sequence();
        test_timeout();
        test_run_drop();
        test_simultaneous();
        test_rst_mid();
        checks++;
        if (exp_idx_q.size() !== 0) begin
            errors++;
            $display("FAIL missing_starts got %0d pending required 0", exp_idx_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_controller.md
LED_SEQ_CONTROLLER -- requirements
Module: led_seq_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of LED channels, 2..16.
REQ-002 SHALL have parameter GAP, default 6'd20: idle cycles between channel steps; 0 is treated as 1.
REQ-003 SHALL have parameter TIMEOUT, default 8'd200: maximum WAIT cycles before the watchdog fires; minimum 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on posedge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port run, input, 1: level; enables sequencing.
REQ-007 SHALL have port step_done, input, 1: one-cycle pulse from the downstream PWM_controller en output.
REQ-008 SHALL have port start, output, 1: one-cycle pulse that drives the downstream PWM_controller start input.
REQ-009 SHALL have port ch_sel, output, NUM_CH: one-hot LED enable that gates the PWM output per channel.
REQ-010 SHALL have port ch_idx, output, $clog2(NUM_CH): current channel index.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port cycle_done, output, 1: one-cycle pulse when the index returns to 0.
REQ-013 SHALL have port err, output, 1: sticky watchdog flag.

Function
REQ-014 SHALL implement the states IDLE, START, WAIT and GAP.
REQ-015 IDLE SHALL go to START when run=1, and SHALL clear err on that transition.
REQ-016 START SHALL last exactly 1 cycle with start=1, then SHALL go to WAIT and clear the watchdog count.
REQ-017 WAIT SHALL go to GAP when step_done=1, and SHALL count cycles otherwise.
REQ-018 When the WAIT count reaches TIMEOUT-1 without step_done, WAIT SHALL set err=1 and go to GAP.
REQ-019 When step_done and the timeout occur in the same cycle, step_done SHALL win and err SHALL be unchanged.
REQ-020 GAP SHALL last max(GAP,1) cycles; on its final cycle the index SHALL advance, then the block SHALL go to START if run=1, else to IDLE.
REQ-021 The index SHALL wrap from NUM_CH-1 to 0, and cycle_done SHALL pulse in the cycle the index is updated to 0.
REQ-022 step_done outside WAIT SHALL be ignored.
REQ-023 run=0 during START, WAIT or GAP SHALL NOT abort; the current channel completes including its GAP.
REQ-024 ch_sel SHALL equal one-hot(ch_idx) in START and WAIT, and SHALL be all-zero in IDLE and GAP.
REQ-025 start, ch_sel, busy and cycle_done SHALL be registered outputs.

Reset
REQ-026 While rst=1, all outputs SHALL immediately be: start=0, ch_sel=0, ch_idx=0, busy=0, cycle_done=0, err=0.
REQ-027 While rst=1, the state SHALL be IDLE, the counters 0 and the direction up.
REQ-028 rst asserted mid-operation SHALL abandon the current step without a further start pulse.

Configuration
REQ-029 With LED_SEQ_PINGPONG_EN defined, the index SHALL bounce 0..NUM_CH-1..0 without repeating endpoints, and cycle_done SHALL pulse on return to 0.
REQ-030 Without LED_SEQ_PINGPONG_EN, the direction register SHALL be absent and the index SHALL wrap per REQ-021.

Structure
REQ-031 The state enum and the counter width constants SHALL live in the shared package led_anim_pkg.
REQ-032 Sub-module led_seq_timer (loadable down-counter with zero flag) SHALL be shared by the GAP and watchdog counts, as they are never active together.

Verification (NUM_CH=4, GAP=3, TIMEOUT=50)
REQ-033 Reset, then run=1 with step_done 5 cycles after each start -> start pulses with ch_idx 0,1,2,3,0; consecutive start pulses 10 cycles apart; cycle_done pulses once at the 3->0 update.
REQ-034 step_done never returned -> err=1 after 50 WAIT cycles, ch_sel=0 for 3 cycles, next start at ch_idx=1.
REQ-035 step_done in the same cycle as the timeout -> err stays 0 and the index advances normally.
REQ-036 run dropped during WAIT at ch_idx=2, step_done 4 cycles later -> after GAP: ch_idx=3, busy=0, no further start; err cleared on the next run=1.
REQ-037 With LED_SEQ_PINGPONG_EN -> ch_idx sequence 0,1,2,3,2,1,0, with cycle_done at the final 0; without it -> 0,1,2,3,0.
REQ-038 rst pulsed mid-WAIT at ch_idx=2 -> all outputs 0 in the same cycle; after release with run=1, the next start is at ch_idx=0.
